// File: rtl/demux_route.sv
// Registered 1-to-2 word router with a 2-entry FWFT buffer
// and a delivered-word counter per destination.
module demux_route_buf #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    pop     = (state_q != EMPTY) && pop_ready;
    if (pop) cnt_d = cnt_q + CNT_W'(1);
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = push_data;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          state_d = FULL;
          tail_d  = push_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // push cannot occur here: in_ready is low while FULL
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign valid = (state_q != EMPTY);
  assign full  = (state_q == FULL);
  assign data  = head_q;
  assign cnt   = cnt_q;

endmodule

module demux_route #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic full0, full1;
  logic push0, push1;

  // no bypass: readiness looks only at registered occupancy
  assign in_ready = !reset && (in_sel ? !full1 : !full0);
  assign push0    = in_valid && in_ready && !in_sel;
  assign push1    = in_valid && in_ready && in_sel;

  demux_route_buf #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_buf0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push0),
    .push_data (in_data),
    .pop_ready (out0_ready),
    .valid     (out0_valid),
    .full      (full0),
    .data      (out0_data),
    .cnt       (cnt0)
  );

  demux_route_buf #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_buf1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push1),
    .push_data (in_data),
    .pop_ready (out1_ready),
    .valid     (out1_valid),
    .full      (full1),
    .data      (out1_data),
    .cnt       (cnt1)
  );

endmodule

// File: tb/tb_demux_route.sv
// Scoreboard bench for demux_route: driver queues expected
// words on acceptance, a negedge monitor checks every pop.
module tb_demux_route;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;

  int checks = 0;
  int failures = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];

  always #5 clk = ~clk;

  demux_route dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshakes happen at the next posedge; inputs are stable
  // from posedge+1 so negedge sees exactly what the edge will.
  always @(negedge clk) begin
    logic [15:0] e;
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out0_unexpected: got %0h expected none",
                   out0_data);
        end else begin
          e = q0.pop_front();
          chk("out0_data", {16'h0, out0_data}, {16'h0, e});
        end
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out1_unexpected: got %0h expected none",
                   out1_data);
        end else begin
          e = q1.pop_front();
          chk("out1_data", {16'h0, out1_data}, {16'h0, e});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic s,
                      input int max_wait);
    bit acc;
    acc = 0;
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    for (int i = 0; i < max_wait && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        if (s) q1.push_back(d);
        else   q0.push_back(d);
      end
      tick();
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no accept expected accept of %0h",
               d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    in_data    = '0;
    in_sel     = 1'b0;
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("ready_in_reset", {31'h0, in_ready}, 32'h0);
    tick();
    reset = 1'b0;

    // reset / idle
    @(negedge clk);
    chk("rst_v0", {31'h0, out0_valid}, 32'h0);
    chk("rst_v1", {31'h0, out1_valid}, 32'h0);
    chk("rst_cnt0", {24'h0, cnt0}, 32'h0);
    chk("rst_cnt1", {24'h0, cnt1}, 32'h0);
    chk("rst_d0", {16'h0, out0_data}, 32'h0);
    chk("rst_d1", {16'h0, out1_data}, 32'h0);
    chk("rst_ready", {31'h0, in_ready}, 32'h1);
    tick();

    // alternate routing
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    send(16'h1111, 1'b0, 1);
    @(negedge clk);
    chk("lat0_v", {31'h0, out0_valid}, 32'h1);
    chk("lat0_d", {16'h0, out0_data}, 32'h1111);
    tick();
    send(16'h2222, 1'b1, 1);
    @(negedge clk);
    chk("lat1_v", {31'h0, out1_valid}, 32'h1);
    chk("lat1_d", {16'h0, out1_data}, 32'h2222);
    tick();
    send(16'h3333, 1'b0, 1);
    idle(2);
    chk("alt_cnt0", {24'h0, cnt0}, 32'd2);
    chk("alt_cnt1", {24'h0, cnt1}, 32'd1);
    tick();

    // backpressure fill
    out0_ready = 1'b0;
    send(16'hA001, 1'b0, 1);
    send(16'hA002, 1'b0, 1);
    in_data  = 16'hA003;
    in_sel   = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_full_ready", {31'h0, in_ready}, 32'h0);
    chk("bp_hold_d0", {16'h0, out0_data}, 32'hA001);
    tick();
    @(negedge clk);
    chk("bp_hold_d0b", {16'h0, out0_data}, 32'hA001);
    tick();
    out0_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_bypass", {31'h0, in_ready}, 32'h0);
    tick();
    send(16'hA003, 1'b0, 1);
    idle(3);
    chk("bp_drain_v0", {31'h0, out0_valid}, 32'h0);
    chk("bp_cnt0", {24'h0, cnt0}, 32'd5);
    tick();

    // isolation: B0 full and stalled, B1 still flows
    out0_ready = 1'b0;
    send(16'hC001, 1'b0, 1);
    send(16'hC002, 1'b0, 1);
    send(16'hB0B0, 1'b1, 1);
    @(negedge clk);
    chk("iso_v1", {31'h0, out1_valid}, 32'h1);
    chk("iso_d1", {16'h0, out1_data}, 32'hB0B0);
    chk("iso_d0", {16'h0, out0_data}, 32'hC001);
    tick();
    out0_ready = 1'b1;
    idle(3);
    chk("iso_cnt0", {24'h0, cnt0}, 32'd7);
    chk("iso_cnt1", {24'h0, cnt1}, 32'd2);
    tick();

    // simultaneous push and pop in ONE
    out1_ready = 1'b0;
    send(16'h0005, 1'b1, 1);
    out1_ready = 1'b1;
    send(16'h0006, 1'b1, 1);
    out1_ready = 1'b0;
    @(negedge clk);
    chk("pp_v1", {31'h0, out1_valid}, 32'h1);
    chk("pp_d1", {16'h0, out1_data}, 32'h0006);
    chk("pp_cnt1", {24'h0, cnt1}, 32'd3);
    chk("pp_ready", {31'h0, in_ready}, 32'h1);
    tick();
    out1_ready = 1'b1;
    idle(2);
    chk("pp_cnt1b", {24'h0, cnt1}, 32'd4);
    tick();

    // counter wrap: 7 + 248 = 255, then one more wraps to 0
    for (int i = 0; i < 248; i++) send(16'h4000 + 16'(i), 1'b0, 2);
    idle(2);
    chk("wrap_255", {24'h0, cnt0}, 32'd255);
    tick();
    send(16'h5A5A, 1'b0, 1);
    idle(2);
    chk("wrap_0", {24'h0, cnt0}, 32'd0);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    tick();

    // mid-operation reset with both buffers full
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(16'hD001, 1'b0, 1);
    send(16'hD002, 1'b0, 1);
    send(16'hE001, 1'b1, 1);
    send(16'hE002, 1'b1, 1);
    @(negedge clk);
    chk("pre_rst_cnt1", {24'h0, cnt1}, 32'd4);
    tick();
    reset      = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mr_v0", {31'h0, out0_valid}, 32'h0);
    chk("mr_v1", {31'h0, out1_valid}, 32'h0);
    chk("mr_cnt0", {24'h0, cnt0}, 32'd0);
    chk("mr_cnt1", {24'h0, cnt1}, 32'd0);
    chk("mr_d0", {16'h0, out0_data}, 32'h0);
    chk("mr_d1", {16'h0, out1_data}, 32'h0);
    chk("mr_ready", {31'h0, in_ready}, 32'h1);
    idle(5);
    chk("mr_quiet_cnt0", {24'h0, cnt0}, 32'd0);
    chk("mr_quiet_cnt1", {24'h0, cnt1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_route.md
# demux_route

Registered 1-to-2 word router for the datapath: the steering counterpart of the 2:1 source select. It accepts one 16-bit word per cycle on a valid/ready input and delivers it to destination 0 or 1 according to a select bit sampled with the word. Each destination has a 2-entry buffer so that one stalled consumer does not corrupt data bound for the other. Per-destination delivered-word counters support debug and bring-up.

## Interface
- WIDTH, 16, data word width in bits.
- CNT_W, 8, width of each delivered-word counter.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- in_data  in  WIDTH  word to route.
- in_sel  in  1  destination select (0 → out0, 1 → out1), sampled with in_data.
- in_valid  in  1  in_data/in_sel are valid this cycle.
- in_ready  out  1  router can accept the word offered this cycle.
- out0_data  out  WIDTH  head word of buffer 0.
- out0_valid  out  1  buffer 0 non-empty.
- out0_ready  in  1  destination 0 consumes head this cycle.
- out1_data, out1_valid, out1_ready  as out0_*, for destination 1.
- cnt0  out  CNT_W  words popped from buffer 0 since reset.
- cnt1  out  CNT_W  words popped from buffer 1 since reset.

## Operation
- Two independent buffers B0 and B1. Each is 2 entries deep, first-word-fall-through, with a head register and a tail register.
- Each buffer has an occupancy state machine: EMPTY, ONE, FULL.
- Input handshake:
  - in_ready = !reset && (in_sel ? B1 != FULL : B0 != FULL). This is combinational on in_sel and the registered state only.
  - Push into the selected buffer when in_valid && in_ready.
- Output handshake:
  - outN_valid = (BN != EMPTY).
  - outN_data = BN head.
  - Pop when outN_valid && outN_ready.
- Transitions, per buffer (push means a push to this buffer):
  - EMPTY: push → ONE, word loaded into head.
  - ONE: push only → FULL, word loaded into tail.
  - ONE: pop only → EMPTY.
  - ONE: push and pop → ONE, new word loaded into head.
  - FULL: pop → ONE, tail moved to head. A push is impossible here because in_ready is 0.
- No bypass: a word popped from a FULL buffer does not free space in the same cycle. in_ready stays 0 that cycle for words selected to that buffer.
- Buffers are independent. B0 full never blocks words selected to B1, and the reverse holds.
- Ordering: words to the same destination leave in arrival order. There is no ordering guarantee across destinations.
- Counters: cntN increments by 1 on each pop of BN and wraps from 2^CNT_W−1 to 0.
- Output data holds its value while outN_valid && !outN_ready. It changes only on a pop or on a push into EMPTY.

## Timing
- Reset (synchronous, has priority over every other event):
  - Both buffers go to EMPTY.
  - out0_valid, out1_valid, in_ready = 0.
  - out0_data, out1_data, head and tail registers = 0.
  - cnt0, cnt1 = 0.
- Words in flight at reset are discarded. A push or pop presented in the reset cycle has no effect and does not count.
- Latency: a word accepted at edge k is visible on outN at edge k when the buffer was EMPTY, i.e. outN_valid is high in cycle k+1. Behind a resident word it appears after the preceding pop.
- Throughput: one word per cycle per destination with a continuously ready consumer.
- Idle outputs: while outN_valid = 0, outN_data holds its last value (0 after reset).

## Test plan
- Reset, then idle: out*_valid = 0, cnt0 = cnt1 = 0, out*_data = 0, and in_ready = 1 from the first post-reset cycle.
- Alternate routing with both readies high: send 0x1111/sel0, 0x2222/sel1, 0x3333/sel0. Required: out0 delivers 0x1111 then 0x3333, out1 delivers 0x2222, each one cycle after acceptance; cnt0 = 2, cnt1 = 1.
- Backpressure fill: hold out0_ready = 0 and send 0xA001, 0xA002, 0xA003 with sel = 0. Required: first two accepted; in_ready = 0 on the third; out0_data holds 0xA001. Raise out0_ready: 0xA001 and 0xA002 pop in order, and 0xA003 is accepted the cycle after B0 leaves FULL.
- Isolation: B0 FULL and stalled, then send 0xB0B0 with sel = 1. Required: in_ready = 1, and out1 delivers 0xB0B0 next cycle.
- Simultaneous push and pop in ONE: B1 holds 0x0005, out1_ready = 1, push 0x0006 to B1 in the same cycle. Required: state stays ONE, out1_data = 0x0006 next cycle, cnt1 += 1.
- Counter wrap and mid-operation reset: pop 256 words from B0 (cnt0 goes 255 → 0). Then assert reset with both buffers FULL. Required: next cycle all valids 0, counters 0, and the previously buffered words never appear.
